// File: rtl/psg_core_multichannel.sv
// Parametrised AY-3-8910-style PSG core: bus decoder and register file, N tone generators,
// one noise and one envelope generator, log attenuation and a saturating registered mixer.
module psg_core_multichannel #(
  parameter int unsigned NUM_CHANNELS        = 3,
  parameter int unsigned ADDR_BITS           = 4,
  parameter int unsigned CHIP_SELECT_MASK    = 0,
  parameter int unsigned CLOCK_DIV_LOG2      = 4,
  parameter int unsigned CHANNEL_OUTPUT_BITS = 8,
  parameter int unsigned MASTER_OUTPUT_BITS  = 8
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [7:0]                    data_in,
  input  logic                          bdir,
  input  logic                          bc1,
  output logic [7:0]                    data_out,
  output logic                          data_oe,
  output logic [MASTER_OUTPUT_BITS-1:0] master_out
);
  localparam int unsigned N         = NUM_CHANNELS;
  localparam int unsigned B         = CHANNEL_OUTPUT_BITS;
  localparam int unsigned M         = MASTER_OUTPUT_BITS;
  localparam int unsigned CS_W      = 8 - ADDR_BITS;
  localparam int unsigned NREG      = 3 * N + 5;
  localparam int unsigned NADDR     = 2 ** ADDR_BITS;
  localparam int unsigned A_NOISE   = 2 * N;
  localparam int unsigned A_MIX     = 2 * N + 1;
  localparam int unsigned A_AMP     = 2 * N + 2;
  localparam int unsigned A_EFINE   = 3 * N + 2;
  localparam int unsigned A_ECOARSE = 3 * N + 3;
  localparam int unsigned A_ESHAPE  = 3 * N + 4;
  localparam int unsigned SUM_W     = B + 2;
  localparam logic [SUM_W-1:0] FULL = SUM_W'((2 ** B) - 1);

  typedef enum logic {ENV_RAMP, ENV_HOLD} env_state_t;

  // Implemented bits per register address; zero for unimplemented addresses.
  function automatic logic [7:0] reg_mask(input logic [ADDR_BITS-1:0] a);
    int unsigned ai;
    ai = 32'(a);
    if (ai < A_NOISE)        reg_mask = ai[0] ? 8'h0F : 8'hFF;
    else if (ai == A_NOISE)  reg_mask = 8'h1F;
    else if (ai == A_MIX)    reg_mask = 8'((1 << (2 * N)) - 1);
    else if (ai < A_EFINE)   reg_mask = 8'h1F;
    else if (ai < A_ESHAPE)  reg_mask = 8'hFF;
    else if (ai == A_ESHAPE) reg_mask = 8'h0F;
    else                     reg_mask = 8'h00;
  endfunction

  // Full scale times 2^((L-15)/2), from a Q16 factor table with round-half-up.
  function automatic logic [B-1:0] vol_lut(input logic [3:0] l);
    logic [63:0] f;
    logic [63:0] p;
    case (l)
      4'd15:   f = 64'd65536;
      4'd14:   f = 64'd46341;
      4'd13:   f = 64'd32768;
      4'd12:   f = 64'd23170;
      4'd11:   f = 64'd16384;
      4'd10:   f = 64'd11585;
      4'd9:    f = 64'd8192;
      4'd8:    f = 64'd5793;
      4'd7:    f = 64'd4096;
      4'd6:    f = 64'd2896;
      4'd5:    f = 64'd2048;
      4'd4:    f = 64'd1448;
      4'd3:    f = 64'd1024;
      4'd2:    f = 64'd724;
      4'd1:    f = 64'd512;
      default: f = 64'd0;
    endcase
    p = 64'((2 ** B) - 1) * f + 64'd32768;
    vol_lut = B'(p >> 16);
  endfunction

  logic                 active;
  logic [ADDR_BITS-1:0] addr;
  logic [7:0]           regs [NADDR];
  logic                 cs_match;
  logic                 env_restart;

  assign cs_match    = (data_in[7:ADDR_BITS] == CS_W'(CHIP_SELECT_MASK));
  assign env_restart = bdir & ~bc1 & active & (addr == ADDR_BITS'(A_ESHAPE));

  // Bus decode, register file and one-cycle read-back.
  always_ff @(posedge clk) begin
    if (reset) begin
      active   <= 1'b0;
      addr     <= '0;
      data_out <= '0;
      data_oe  <= 1'b0;
      for (int i = 0; i < int'(NADDR); i++) regs[ADDR_BITS'(i)] <= '0;
    end else begin
      data_out <= '0;
      data_oe  <= 1'b0;
      unique case ({bdir, bc1})
        2'b11: begin
          active <= cs_match;
          if (cs_match) addr <= data_in[ADDR_BITS-1:0];
        end
        2'b10: if (active && 32'(addr) < NREG) regs[addr] <= data_in & reg_mask(addr);
        2'b01: if (active) begin
          data_out <= regs[addr] & reg_mask(addr);
          data_oe  <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  logic [CLOCK_DIV_LOG2-1:0] pre_cnt;
  logic [3:0]                env_div;
  logic                      tick;
  logic                      env_tick;

  assign tick     = &pre_cnt;
  assign env_tick = tick & (&env_div);

  always_ff @(posedge clk) begin
    if (reset) begin
      pre_cnt <= '0;
      env_div <= '0;
    end else begin
      pre_cnt <= pre_cnt + 1'b1;
      if (tick) env_div <= env_div + 4'd1;
    end
  end

  // Noise: period counter clocking a 17-bit LFSR.
  logic [4:0]  noise_period;
  logic [4:0]  noise_cnt;
  logic [5:0]  noise_limit;
  logic [16:0] lfsr;

  assign noise_period = regs[ADDR_BITS'(A_NOISE)][4:0];
  assign noise_limit  = (noise_period == 5'd0) ? 6'd1 : {1'b0, noise_period};

  always_ff @(posedge clk) begin
    if (reset) begin
      noise_cnt <= '0;
      lfsr      <= 17'd1;
    end else if (tick) begin
      if ({1'b0, noise_cnt} + 6'd1 >= noise_limit) begin
        noise_cnt <= '0;
        lfsr      <= {lfsr[0] ^ lfsr[3], lfsr[16:1]};
      end else begin
        noise_cnt <= noise_cnt + 5'd1;
      end
    end
  end

  // Envelope generator.
  env_state_t  env_state, env_state_nx;
  logic [15:0] env_cnt, env_cnt_nx;
  logic [3:0]  env_level, env_level_nx;
  logic        env_up, env_up_nx;
  logic [15:0] env_period;
  logic [16:0] env_limit;
  logic        env_cont, env_alt, env_hold;

  assign env_period = {regs[ADDR_BITS'(A_ECOARSE)], regs[ADDR_BITS'(A_EFINE)]};
  assign env_limit  = (env_period == 16'd0) ? 17'd1 : {1'b0, env_period};
  assign env_cont   = regs[ADDR_BITS'(A_ESHAPE)][3];
  assign env_alt    = regs[ADDR_BITS'(A_ESHAPE)][1];
  assign env_hold   = regs[ADDR_BITS'(A_ESHAPE)][0];

  always_ff @(posedge clk) begin
    if (reset) begin
      env_state <= ENV_RAMP;
      env_cnt   <= '0;
      env_level <= '0;
      env_up    <= 1'b0;
    end else begin
      env_state <= env_state_nx;
      env_cnt   <= env_cnt_nx;
      env_level <= env_level_nx;
      env_up    <= env_up_nx;
    end
  end

  always_comb begin
    env_state_nx = env_state;
    env_cnt_nx   = env_cnt;
    env_level_nx = env_level;
    env_up_nx    = env_up;
    if (env_restart) begin
      env_state_nx = ENV_RAMP;
      env_cnt_nx   = '0;
      env_up_nx    = data_in[2];
      env_level_nx = data_in[2] ? 4'd0 : 4'd15;
    end else if (env_tick) begin
      if ({1'b0, env_cnt} + 17'd1 >= env_limit) begin
        env_cnt_nx = '0;
        if (env_state == ENV_RAMP) begin
          if (env_up ? (env_level == 4'd15) : (env_level == 4'd0)) begin
            if (!env_cont) begin
              env_level_nx = 4'd0;
              env_state_nx = ENV_HOLD;
            end else if (env_hold) begin
              env_level_nx = env_alt ? ~env_level : env_level;
              env_state_nx = ENV_HOLD;
            end else begin
              env_up_nx    = env_up ^ env_alt;
              env_level_nx = (env_up ^ env_alt) ? 4'd0 : 4'd15;
            end
          end else begin
            env_level_nx = env_up ? env_level + 4'd1 : env_level - 4'd1;
          end
        end
      end else begin
        env_cnt_nx = env_cnt + 16'd1;
      end
    end
  end

  logic [N-1:0]   tone_dis, noise_dis;
  logic [N*B-1:0] vol_bus;

  assign tone_dis  = regs[ADDR_BITS'(A_MIX)][N-1:0];
  assign noise_dis = regs[ADDR_BITS'(A_MIX)][2*N-1:N];

  // Per channel: tone generator, gate and attenuation.
  for (genvar i = 0; i < int'(N); i++) begin : g_ch
    logic [11:0] period;
    logic [12:0] limit;
    logic [11:0] cnt;
    logic        tone_q;
    logic [4:0]  amp;
    logic [3:0]  ctrl;
    logic        gate;

    assign period = {regs[ADDR_BITS'(2 * i + 1)][3:0], regs[ADDR_BITS'(2 * i)]};
    assign limit  = (period == 12'd0) ? 13'd1 : {1'b0, period};
    assign amp    = regs[ADDR_BITS'(A_AMP + i)][4:0];
    assign ctrl   = amp[4] ? env_level : amp[3:0];
    assign gate   = (tone_dis[i] | tone_q) & (noise_dis[i] | lfsr[0]);
    assign vol_bus[i*B +: B] = gate ? vol_lut(ctrl) : '0;

    always_ff @(posedge clk) begin
      if (reset) begin
        cnt    <= '0;
        tone_q <= 1'b0;
      end else if (tick) begin
        if ({1'b0, cnt} + 13'd1 >= limit) begin
          cnt    <= '0;
          tone_q <= ~tone_q;
        end else begin
          cnt <= cnt + 12'd1;
        end
      end
    end
  end

  logic [SUM_W-1:0] sum_c;
  logic [B-1:0]     sat_c;

  always_comb begin
    sum_c = '0;
    for (int i = 0; i < int'(N); i++) sum_c = sum_c + SUM_W'(vol_bus[i*B +: B]);
    sat_c = (sum_c > FULL) ? '1 : sum_c[B-1:0];
  end

  always_ff @(posedge clk) begin
    if (reset) master_out <= '0;
    else       master_out <= sat_c[B-1:B-M];
  end
endmodule

// File: tb/tb_psg_core_multichannel.sv
// Self-checking bench for psg_core_multichannel (default 3-channel, 8-bit configuration).
module tb_psg_core_multichannel;
  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] data_in;
  logic       bdir, bc1;
  logic [7:0] data_out;
  logic       data_oe;
  logic [7:0] master_out;

  always #5 clk = ~clk;

  psg_core_multichannel dut (
    .clk(clk), .reset(reset), .data_in(data_in), .bdir(bdir), .bc1(bc1),
    .data_out(data_out), .data_oe(data_oe), .master_out(master_out)
  );

  int n_cmp = 0;
  int n_err = 0;
  int unsigned sb_q[$];

  logic [7:0] mask_tbl [14] = '{8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'hFF, 8'h0F, 8'h1F,
                                8'h3F, 8'h1F, 8'h1F, 8'h1F, 8'hFF, 8'hFF, 8'h0F};
  logic [7:0] vol_tbl [16] = '{8'd0, 8'd2, 8'd3, 8'd4, 8'd6, 8'd8, 8'd11, 8'd16,
                               8'd23, 8'd32, 8'd45, 8'd64, 8'd90, 8'd128, 8'd180, 8'd255};
  logic [7:0] sat_a [7] = '{8'h0F, 8'h0D, 8'h0D, 8'h0C, 8'h0B, 8'h0E, 8'h00};
  logic [7:0] sat_b [7] = '{8'h00, 8'h00, 8'h0D, 8'h0C, 8'h0B, 8'h0D, 8'h00};
  logic [7:0] sat_c [7] = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0B, 8'h00, 8'h00};
  logic [7:0] sat_x [7] = '{8'd255, 8'd128, 8'd255, 8'd180, 8'd192, 8'd255, 8'd0};
  logic [7:0] shadow [14];

  task automatic check(input string tag, input int unsigned got, input int unsigned exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic sb_check(input string tag, input int unsigned got);
    if (sb_q.size() == 0) check({tag, "_sb_empty"}, 32'(sb_q.size()), 1);
    else check(tag, got, sb_q.pop_front());
  endtask

  task automatic bus(input logic [1:0] ctl, input logic [7:0] d);
    {bdir, bc1} = ctl;
    data_in = d;
    @(posedge clk);
    #1;
    {bdir, bc1} = 2'b00;
    data_in = 8'h00;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wr_reg(input int a, input logic [7:0] d);
    bus(2'b11, 8'(a));
    bus(2'b10, d);
  endtask

  task automatic rd_check(input string tag, input int a, input int unsigned exp);
    bus(2'b11, 8'(a));
    sb_q.push_back(exp);
    bus(2'b01, 8'h00);
    sb_check(tag, 32'({data_oe, data_out}));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
  endtask

  task automatic wait_change(input string tag, input int budget, output int cycles,
                             output logic [7:0] val);
    logic [7:0] prev;
    prev = master_out;
    cycles = 0;
    while (master_out == prev && cycles < budget) begin
      @(posedge clk);
      #1;
      cycles++;
    end
    val = master_out;
    check({tag, "_seen"}, 32'(master_out != prev), 1);
  endtask

  initial begin
    #5ms;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int c;
    logic [7:0] v, nv, d;

    reset = 1'b1; bdir = 1'b0; bc1 = 1'b0; data_in = 8'h00;
    idle(3);
    sb_q.push_back(0); sb_check("rst_master", 32'(master_out));
    sb_q.push_back(0); sb_check("rst_oe", 32'(data_oe));
    sb_q.push_back(0); sb_check("rst_dout", 32'(data_out));
    reset = 1'b0;

    // Read-back and masking
    wr_reg(1, 8'hFF);
    rd_check("rd_r1", 1, 9'h10F);
    idle(1);
    sb_q.push_back(0); sb_check("oe_drop", 32'({data_oe, data_out}));
    wr_reg(7, 8'hFF);
    rd_check("rd_r7", 7, 9'h13F);
    rd_check("rd_r14", 14, 9'h100);
    wr_reg(14, 8'h55);
    rd_check("rd_r14_wr", 14, 9'h100);
    for (int a = 0; a < 14; a++) begin
      d = 8'($urandom);
      shadow[a] = d & mask_tbl[a];
      wr_reg(a, d);
      rd_check($sformatf("map_r%0d", a), a, {23'd0, 1'b1, shadow[a]});
    end
    for (int a = 0; a < 14; a++) rd_check($sformatf("reread_r%0d", a), a, {23'd0, 1'b1, shadow[a]});

    // Chip select
    wr_reg(1, 8'h05);
    bus(2'b11, 8'h12);
    bus(2'b10, 8'hAA);
    sb_q.push_back(0);
    bus(2'b01, 8'h00);
    sb_check("cs_rd_off", 32'({data_oe, data_out}));
    rd_check("cs_reenable", 1, 9'h105);

    // Tone timing: half-period 5 ticks x 16 clk
    do_reset();
    wr_reg(0, 8'h05); wr_reg(7, 8'h3E); wr_reg(8, 8'h0F);
    wait_change("tone_sync0", 200, c, v);
    wait_change("tone_sync1", 200, c, v);
    check("tone_lvl0", 32'(v == 8'd0 || v == 8'd255), 1);
    for (int k = 0; k < 4; k++) begin
      sb_q.push_back(80);
      sb_q.push_back((v == 8'd0) ? 255 : 0);
      wait_change("tone", 200, c, nv);
      sb_check("tone_period", 32'(c));
      sb_check("tone_level", 32'(nv));
      v = nv;
    end

    // Envelope ramp up then hold, then restart
    do_reset();
    wr_reg(7, 8'h3F); wr_reg(8, 8'h10); wr_reg(11, 8'h01); wr_reg(13, 8'h0D);
    idle(1);
    sb_q.push_back(0); sb_check("env_start", 32'(master_out));
    for (int l = 1; l < 16; l++) begin
      wait_change("env", 300, c, v);
      sb_q.push_back(32'(vol_tbl[l]));
      sb_check($sformatf("env_lvl%0d", l), 32'(v));
      if (l > 1) begin
        sb_q.push_back(256);
        sb_check("env_step", 32'(c));
      end
    end
    idle(600);
    sb_q.push_back(255); sb_check("env_hold", 32'(master_out));
    wr_reg(13, 8'h0D);
    idle(1);
    sb_q.push_back(0); sb_check("env_restart", 32'(master_out));
    wait_change("env_re", 300, c, v);
    sb_q.push_back(32'(vol_tbl[1])); sb_check("env_re_lvl1", 32'(v));

    // Mixer saturation
    do_reset();
    wr_reg(7, 8'h3F); wr_reg(8, 8'h0F); wr_reg(9, 8'h0F); wr_reg(10, 8'h0F);
    idle(2);
    sb_q.push_back(255); sb_check("sat_all", 32'(master_out));
    for (int k = 0; k < 7; k++) begin
      wr_reg(8, sat_a[k]); wr_reg(9, sat_b[k]); wr_reg(10, sat_c[k]);
      idle(2);
      sb_q.push_back(32'(sat_x[k]));
      sb_check($sformatf("sat_case%0d", k), 32'(master_out));
    end

    // Reset during an active tone and a read cycle
    do_reset();
    wr_reg(0, 8'h05); wr_reg(7, 8'h3E); wr_reg(8, 8'h0F);
    for (int k = 0; k < 300 && master_out != 8'hFF; k++) idle(1);
    check("pre_rst_tone", 32'(master_out), 255);
    reset = 1'b1; bdir = 1'b0; bc1 = 1'b1;
    idle(1);
    reset = 1'b0; bc1 = 1'b0;
    sb_q.push_back(0); sb_check("midrst_master", 32'(master_out));
    sb_q.push_back(0); sb_check("midrst_oe", 32'(data_oe));
    idle(100);
    sb_q.push_back(0); sb_check("midrst_quiet", 32'(master_out));
    for (int a = 0; a < 14; a++) rd_check($sformatf("postrst_r%0d", a), a, 9'h100);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
